// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between a 6502-style CPU and a debug/loader port.
// Debug has priority but yields one CPU cycle after MAX_HOLD consecutive grants.
module mem_arbiter #(
    parameter int          MAX_HOLD = 4,
    parameter logic [15:0] ROM_BASE = 16'hF000
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_rdata,
    input  logic        dbg_req,
    input  logic [15:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    input  logic        dbg_we,
    input  logic        dbg_halt,
    output logic        dbg_ack,
    output logic        dbg_rvalid,
    output logic [7:0]  dbg_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        rom_viol,
    output logic [15:0] stall_cnt
);

    localparam int            HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    logic [HW-1:0] hold_cnt_r;
    logic [HW-1:0] hold_cnt_nx_s;
    logic          hold_ok_s;
    logic          dbg_gnt_s;
    logic          cpu_rom_wr_s;
    logic          rom_viol_r;
    logic          dbg_rvalid_r;
    logic [15:0]   stall_cnt_r;

    // Grant decision and shared-port steering.
    always_comb begin
        hold_ok_s    = (hold_cnt_r < HOLD_MAX);
        dbg_gnt_s    = ~reset & dbg_req & (dbg_halt | ~cpu_en | hold_ok_s);
        cpu_rom_wr_s = ~dbg_gnt_s & cpu_en & cpu_we & (cpu_addr >= ROM_BASE);
        cpu_rdy      = ~reset & ~dbg_gnt_s & ~dbg_halt;
        dbg_ack      = dbg_gnt_s;
        if (dbg_gnt_s) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
        // The loader may write ROM; the CPU may not.
        if (reset) begin
            mem_we = 1'b0;
        end else if (dbg_gnt_s) begin
            mem_we = dbg_we;
        end else begin
            mem_we = cpu_en & cpu_we & (cpu_addr < ROM_BASE);
        end
    end

    // Consecutive debug grants against a waiting CPU; halted cycles leave it unchanged.
    always_comb begin
        hold_cnt_nx_s = hold_cnt_r;
        if (dbg_gnt_s & cpu_en & ~dbg_halt) begin
            if (hold_ok_s) begin
                hold_cnt_nx_s = hold_cnt_r + HW'(1);
            end else begin
                hold_cnt_nx_s = hold_cnt_r;
            end
        end else if (~dbg_gnt_s | ~cpu_en) begin
            hold_cnt_nx_s = '0;
        end else begin
            hold_cnt_nx_s = hold_cnt_r;
        end
    end

    // State registers: fairness counter, read-valid, sticky ROM flag, stall counter.
    always_ff @(posedge ph2) begin
        if (reset) begin
            hold_cnt_r   <= '0;
            dbg_rvalid_r <= 1'b0;
            rom_viol_r   <= 1'b0;
            stall_cnt_r  <= 16'd0;
        end else begin
            hold_cnt_r   <= hold_cnt_nx_s;
            dbg_rvalid_r <= dbg_gnt_s & ~dbg_we;
            rom_viol_r   <= rom_viol_r | cpu_rom_wr_s;
            if (cpu_en & ~cpu_rdy & (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign dbg_rvalid = dbg_rvalid_r;
    assign dbg_rdata  = mem_rdata;
    assign cpu_rdata  = mem_rdata;
    assign rom_viol   = rom_viol_r;
    assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a driver runs a reference model
// and queues expected read data; a monitor checks it when the DUT presents it.
module tb_mem_arbiter;

    localparam int          MAX_HOLD = 4;
    localparam logic [15:0] ROM_BASE = 16'hF000;

    logic        ph2 = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_en = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_halt = 1'b0;
    logic [15:0] dbg_addr = 16'h0000;
    logic [7:0]  dbg_wdata = 8'h00;
    logic        dbg_ack, dbg_rvalid;
    logic [7:0]  dbg_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        rom_viol;
    logic [15:0] stall_cnt;

    mem_arbiter #(.MAX_HOLD(MAX_HOLD), .ROM_BASE(ROM_BASE)) dut (
        .ph2(ph2), .reset(reset),
        .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we),
        .dbg_halt(dbg_halt), .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .rom_viol(rom_viol), .stall_cnt(stall_cnt)
    );

    always #5 ph2 = ~ph2;

    // Environment memory: synchronous read, one-cycle latency.
    logic [7:0] env_ram [0:65535];
    always @(posedge ph2) begin
        mem_rdata <= env_ram[mem_addr];
        if (mem_we === 1'b1) env_ram[mem_addr] <= mem_wdata;
    end

    // Reference model state.
    logic [7:0] ref_ram [0:65535];
    int         streak = 0;
    int         m_stall = 0;
    bit         m_viol = 1'b0;
    bit         known = 1'b0;
    bit         mon_en = 1'b0;
    logic [7:0] dq[$];
    logic [7:0] cq[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ce, input logic [15:0] ca,
                         input logic [7:0] cw, input logic cwe,
                         input logic dr, input logic [15:0] da, input logic [7:0] dw,
                         input logic dwe, input logic dh, output logic g);
        logic eg, erdy, ewe;
        logic [15:0] eaddr;
        logic [7:0]  ewd;
        @(negedge ph2);
        reset = rst; cpu_en = ce; cpu_addr = ca; cpu_wdata = cw; cpu_we = cwe;
        dbg_req = dr; dbg_addr = da; dbg_wdata = dw; dbg_we = dwe; dbg_halt = dh;
        if (rst) begin
            eg = 1'b0; erdy = 1'b0; ewe = 1'b0;
        end else begin
            eg   = dr && (dh || !ce || streak < MAX_HOLD);
            erdy = !eg && !dh;
            ewe  = eg ? dwe : (ce && cwe && ca < ROM_BASE);
        end
        eaddr = eg ? da : ca;
        ewd   = eg ? dw : cw;
        #1;
        chk("dbg_ack", dbg_ack, eg);
        chk("cpu_rdy", cpu_rdy, erdy);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, eaddr);
        if (ewe) chk("mem_wdata", mem_wdata, ewd);
        if (known) begin
            chk("rom_viol", rom_viol, m_viol);
            chk("stall_cnt", stall_cnt, m_stall);
        end
        if (rst) begin
            streak = 0; m_stall = 0; m_viol = 1'b0; known = 1'b1;
        end else begin
            if (eg && !dwe) dq.push_back(ref_ram[da]);
            if (!eg && erdy && ce && !cwe) cq.push_back(ref_ram[ca]);
            if (!eg && ce && cwe && ca >= ROM_BASE) m_viol = 1'b1;
            if (ce && !erdy && m_stall < 65535) m_stall++;
            if (eg && ce && !dh) streak = (streak < MAX_HOLD) ? streak + 1 : MAX_HOLD;
            else if (!eg || !ce) streak = 0;
            if (ewe) ref_ram[eaddr] = ewd;
        end
        mon_en = 1'b1;
        g = eg;
    endtask

    // Monitor: read data returns one cycle after the accept.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge ph2);
            #2;
            if (mon_en) begin
                chk("dbg_rvalid", dbg_rvalid, dq.size() != 0);
                if (dq.size() != 0) begin
                    e = dq.pop_front();
                    chk("dbg_rdata", dbg_rdata, e);
                end
                if (cq.size() != 0) begin
                    e = cq.pop_front();
                    chk("cpu_rdata", cpu_rdata, e);
                end
            end
        end
    end

    function automatic logic [15:0] raddr();
        case ($urandom_range(0, 3))
            0:       raddr = 16'h0040 + 16'($urandom_range(0, 15));
            1:       raddr = 16'hF000 + 16'($urandom_range(0, 15));
            2:       raddr = 16'hEFFF;
            default: raddr = 16'hFFFF;
        endcase
    endfunction

    initial begin
        logic        g;
        logic        dr, dwe, dh, ce, cwe;
        logic [15:0] da;
        logic [7:0]  dw;
        for (int i = 0; i < 65536; i++) begin
            ref_ram[i]  = 8'(i) ^ 8'h5A;
            env_ram[i] <= 8'(i) ^ 8'h5A;
        end

        // Reset with a pending debug request: outputs forced inactive.
        drive(1'b1, 1'b1, 16'h0010, 8'h00, 1'b1, 1'b1, 16'h0020, 8'h11, 1'b1, 1'b0, g);
        drive(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0020, 8'h11, 1'b0, 1'b0, g);

        // Halt loader writes the reset vector into ROM.
        drive(1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'hFFFD, 8'hF0, 1'b1, 1'b1, g);
        chk("loader_ack0", g, 1'b1);
        drive(1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'hFFFC, 8'h00, 1'b1, 1'b1, g);
        chk("loader_ack1", g, 1'b1);
        drive(1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'hFFFD, 8'h00, 1'b0, 1'b1, g);

        // CPU ROM write is blocked and latches the violation flag.
        drive(1'b0, 1'b1, 16'hF123, 8'hAA, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, g);
        @(posedge ph2); #1;
        chk("rom_viol_set", rom_viol, 1'b1);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 16'hFFFC, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, g);

        // Fairness: D,D,D,D,C and eight stalls over ten cycles.
        drive(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, g);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 16'h0010, 8'h00, 1'b0, 1'b1, 16'h0020, 8'(i), 1'b1, 1'b0, g);
            chk("fair_pattern", g, (i % 5) != 4);
        end
        @(posedge ph2); #1;
        chk("fair_stall8", stall_cnt, 16'd8);

        // Debug read of a freshly written location.
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0042, 8'hCF, 1'b1, 1'b0, g);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0042, 8'h00, 1'b0, 1'b0, g);
        @(posedge ph2); #1;
        chk("dbg_read_valid", dbg_rvalid, 1'b1);
        chk("dbg_read_data", dbg_rdata, 8'hCF);

        // Idle CPU: debug granted every cycle, no stalls accrue.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0030 + 16'(i), 8'h00, 1'b0, 1'b0, g);
            chk("idle_grant", g, 1'b1);
        end
        chk("idle_stall", stall_cnt, 16'd8);

        // Reset in the accept cycle discards the read.
        drive(1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0042, 8'h00, 1'b0, 1'b0, g);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, g);
        chk("rst_rvalid", dbg_rvalid, 1'b0);
        chk("rst_stall", stall_cnt, 16'd0);
        chk("rst_viol", rom_viol, 1'b0);

        // Randomized traffic; debug requests are held until accepted.
        dr = 1'b0; da = 16'h0000; dw = 8'h00; dwe = 1'b0; g = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!dr || g) begin
                dr  = ($urandom_range(0, 99) < 60);
                da  = raddr();
                dw  = 8'($urandom);
                dwe = $urandom_range(0, 1) == 1;
            end
            dh  = ($urandom_range(0, 99) < 10);
            ce  = ($urandom_range(0, 99) < 80);
            cwe = ($urandom_range(0, 99) < 30);
            drive(($urandom_range(0, 199) == 0), ce, raddr(), 8'($urandom), cwe,
                  dr, da, dw, dwe, dh, g);
        end
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, g);
        @(posedge ph2); #3;
        chk("dq_drained", dq.size(), 0);
        chk("cq_drained", cq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
